// File: rtl/round_ctrl_pkg.sv
// Shared state encoding and default timing constants for the memorization game
// round sequencer and its neighbours (clockdiv, display).
package round_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SHOW   = 3'd2,
      ST_INPUT  = 3'd3,
      ST_RESULT = 3'd4,
      ST_OVER   = 3'd5
   } state_t;

   localparam int DEF_SHOW_CYCLES   = 500_000_000;
   localparam int DEF_SHOW_DEC      = 50_000_000;
   localparam int DEF_SHOW_MIN      = 100_000_000;
   localparam int DEF_RESULT_CYCLES = 200_000_000;
   localparam int DEF_MAX_LIVES     = 3;
   localparam int DEF_CNT_W         = 30;

endpackage

// File: rtl/round_ctrl_phase_timer.sv
// Clearable up-counter with a loadable terminal-count compare; done flags the
// last counted cycle of a phase.
module round_ctrl_phase_timer #(
   parameter int CNT_W = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] termCount,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CNT_W'(1);
   end

   assign done = enable && (count == termCount);

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: new number, level-dependent display window, keyboard input
// window, pass/fail indication, then score/lives bookkeeping.
module round_ctrl
   import round_ctrl_pkg::*;
#(
   parameter int SHOW_CYCLES   = DEF_SHOW_CYCLES,
   parameter int SHOW_DEC      = DEF_SHOW_DEC,
   parameter int SHOW_MIN      = DEF_SHOW_MIN,
   parameter int RESULT_CYCLES = DEF_RESULT_CYCLES,
   parameter int MAX_LIVES     = DEF_MAX_LIVES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ready,
   input  logic       correct,
   output logic       new_num,
   output logic       display_phase,
   output logic       input_phase,
   output logic       result_valid,
   output logic       result_pass,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       game_over
);

   localparam int               CW1        = CNT_W + 1;
   localparam logic [CNT_W-1:0] SHOW_INIT  = CNT_W'(SHOW_CYCLES);
   localparam logic [CNT_W-1:0] SHOW_FLOOR = CNT_W'(SHOW_MIN);
   localparam logic [CNT_W-1:0] SHOW_STEP  = CNT_W'(SHOW_DEC);
   localparam logic [CNT_W-1:0] RES_TERM   = CNT_W'(RESULT_CYCLES - 1);
   localparam logic [CW1-1:0]   SHRINK_MIN = CW1'(SHOW_DEC) + CW1'(SHOW_MIN);
   localparam logic [1:0]       LIVES_INIT = 2'(MAX_LIVES);

   state_t           state, nextState;
   logic [CNT_W-1:0] showLen, showLenNext, termCount;
   logic             timerDone, timerEn, timerClear;
   logic             freshGame, commitPass, commitFail;

   assign timerEn    = (state == ST_SHOW) || (state == ST_RESULT);
   assign timerClear = (nextState != state);
   assign termCount  = (state == ST_RESULT) ? RES_TERM : showLen - CNT_W'(1);

   // compare in one extra bit so a large SHOW_DEC can never wrap below the floor
   assign showLenNext = ({1'b0, showLen} >= SHRINK_MIN) ? showLen - SHOW_STEP : SHOW_FLOOR;

   round_ctrl_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (timerClear),
      .enable    (timerEn),
      .termCount (termCount),
      .done      (timerDone)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState  = state;
      freshGame  = 1'b0;
      commitPass = 1'b0;
      commitFail = 1'b0;
      if (start) begin
         nextState = ST_LOAD;
         freshGame = 1'b1;
      end else begin
         case (state)
            ST_IDLE:   nextState = ST_IDLE;
            ST_LOAD:   nextState = ST_SHOW;
            ST_SHOW:   if (timerDone) nextState = ST_INPUT;
            ST_INPUT: begin
               if (ready) begin
                  nextState  = ST_RESULT;
                  commitPass = correct;
                  commitFail = !correct;
               end
            end
            ST_RESULT: if (timerDone) nextState = (lives == 2'd0) ? ST_OVER : ST_LOAD;
            ST_OVER:   nextState = ST_OVER;
            default:   nextState = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score         <= '0;
         lives         <= LIVES_INIT;
         showLen       <= SHOW_INIT;
         result_pass   <= 1'b0;
         new_num       <= 1'b0;
         display_phase <= 1'b0;
         input_phase   <= 1'b0;
         result_valid  <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         if (freshGame) begin
            score   <= '0;
            lives   <= LIVES_INIT;
            showLen <= SHOW_INIT;
         end else if (commitPass) begin
            result_pass <= 1'b1;
            score       <= (score == 8'hFF) ? score : score + 8'd1;
            showLen     <= showLenNext;
         end else if (commitFail) begin
            result_pass <= 1'b0;
            lives       <= (lives == 2'd0) ? lives : lives - 2'd1;
         end
         // outputs decoded from the next state so they are flops aligned with the state
         new_num       <= (nextState == ST_LOAD);
         display_phase <= (nextState == ST_SHOW);
         input_phase   <= (nextState == ST_INPUT);
         result_valid  <= (nextState == ST_RESULT);
         game_over     <= (nextState == ST_OVER);
      end
   end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl with shortened timing; round verdicts
// are predicted into a queue when ready is driven and checked in RESULT.
module tb_round_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, ready, correct;
   logic       new_num, display_phase, input_phase, result_valid, result_pass, game_over;
   logic [7:0] score;
   logic [1:0] lives;

   always #5 clk = ~clk;

   round_ctrl #(
      .SHOW_CYCLES(10), .SHOW_DEC(3), .SHOW_MIN(4),
      .RESULT_CYCLES(5), .MAX_LIVES(3), .CNT_W(30)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .correct(correct),
      .new_num(new_num), .display_phase(display_phase), .input_phase(input_phase),
      .result_valid(result_valid), .result_pass(result_pass), .score(score),
      .lives(lives), .game_over(game_over)
   );

   typedef struct packed {
      logic       pass;
      logic [7:0] score;
      logic [1:0] lives;
   } exp_t;

   exp_t sbQ[$];
   int   errors = 0;
   int   checks = 0;
   int   mScore, mLives, mShow;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic newGameModel();
      mScore = 0;
      mLives = 3;
      mShow  = 10;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
      newGameModel();
   endtask

   task automatic runRound(input logic corr, input bit readyInShow);
      int   n;
      int   expShow;
      exp_t e;
      n = 0;
      while (!new_num && n < 50) begin
         tick();
         n++;
      end
      check("new_num", new_num, 1);
      expShow = mShow;
      tick();
      check("new_num_once", new_num, 0);
      n = 0;
      while (display_phase && n < 50) begin
         ready   = readyInShow && (n == 3);
         correct = 1'b1;
         tick();
         n++;
      end
      ready = 1'b0;
      check("show_len", n, expShow);
      check("input_phase", input_phase, 1);
      check("score_in_input", score, mScore);
      check("lives_in_input", lives, mLives);
      ready   = 1'b1;
      correct = corr;
      if (corr) begin
         mScore = (mScore < 255) ? mScore + 1 : 255;
         mShow  = (mShow - 3 >= 4) ? mShow - 3 : 4;
      end else begin
         mLives--;
      end
      e.pass  = corr;
      e.score = 8'(mScore);
      e.lives = 2'(mLives);
      sbQ.push_back(e);
      tick();
      ready   = 1'b0;
      correct = 1'b0;
      check("result_valid", result_valid, 1);
      if (sbQ.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sbQ.pop_front();
         check("result_pass", result_pass, e.pass);
         check("score", score, e.score);
         check("lives", lives, e.lives);
      end
      n = 0;
      while (result_valid && n < 50) begin
         tick();
         n++;
      end
      check("result_len", n, 5);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  sawNew;
      rst = 1'b1; start = 1'b0; ready = 1'b0; correct = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (20) tick();
      check("idle_outs", {new_num, display_phase, input_phase, result_valid,
                          result_pass, game_over, score}, 0);
      check("idle_lives", lives, 3);

      // passes shrink the display window 10 -> 7 -> 4 and then hold at the floor
      pulseStart();
      runRound(1'b1, 1'b0);
      runRound(1'b1, 1'b0);
      runRound(1'b1, 1'b0);
      runRound(1'b1, 1'b0);
      runRound(1'b1, 1'b1);

      runRound(1'b0, 1'b0);
      runRound(1'b0, 1'b0);
      runRound(1'b0, 1'b0);
      check("game_over", game_over, 1);
      check("over_score", score, mScore);
      sawNew = 1'b0;
      repeat (10) begin
         tick();
         if (new_num) sawNew = 1'b1;
      end
      check("over_no_new_num", sawNew, 0);
      check("over_held", game_over, 1);
      check("over_score_held", score, mScore);

      pulseStart();
      check("restart_load", new_num, 1);
      check("restart_over_clr", game_over, 0);
      check("restart_score", score, 0);
      check("restart_lives", lives, 3);
      runRound(1'b1, 1'b0);

      n = 0;
      while (!input_phase && n < 50) begin
         tick();
         n++;
      end
      check("reach_input", input_phase, 1);
      start = 1'b1; ready = 1'b1; correct = 1'b1;
      tick();
      start = 1'b0; ready = 1'b0; correct = 1'b0;
      newGameModel();
      check("abort_load", new_num, 1);
      check("abort_score", score, 0);
      check("abort_lives", lives, 3);
      check("abort_no_result", result_valid, 0);
      runRound(1'b1, 1'b0);

      tick();
      tick();
      tick();
      check("mid_show", display_phase, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_outs", {new_num, display_phase, input_phase, result_valid,
                         result_pass, game_over, score}, 0);
      check("rst_lives", lives, 3);
      repeat (3) tick();
      check("rst_idle", {new_num, display_phase, input_phase, result_valid, game_over}, 0);
      pulseStart();
      runRound(1'b1, 1'b0);

      for (int i = 0; i < 256; i++) runRound(1'b1, 1'b0);
      check("score_saturated", score, 255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
